// File: rtl/instr_loader.sv
// instr_loader: streams host instruction words into the SPU instruction buffer,
// padding odd-length programs with a NOP so the dual-issue fetch reads whole pairs.
module instr_loader #(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              load_active,
   output logic              load_done,
   output logic [ADDR_W:0]   instr_count,
   output logic              overflow
);

   localparam int unsigned      CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      DRAIN = 3'd2,
      PAD   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                in_ready_q, in_ready_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                load_active_q, load_active_d;
   logic                load_done_q, load_done_d;
   logic                xfer;

   function automatic logic is_busy(input state_t s);
      return (s == LOAD) || (s == DRAIN) || (s == PAD);
   endfunction

   // Next-state, write-port and status computation
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      xfer        = in_valid & in_ready_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            if (xfer) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr_q;
               mem_wdata_d = in_data;
               cnt_d       = cnt_q + CNT_W'(1);
               if (ptr_q != LAST_ADDR) begin
                  ptr_d = ptr_q + ADDR_W'(1);
               end
               // A full buffer always holds an even count, so the pad branch cannot fire there
               if (in_last) begin
                  state_d = cnt_d[0] ? PAD : DONE;
               end else if (ptr_q == LAST_ADDR) begin
                  state_d = DRAIN;
                  ovf_d   = 1'b1;
               end
            end
         end
         DRAIN: begin
            ovf_d = 1'b1;
            if (xfer && in_last) begin
               state_d = DONE;
            end
         end
         PAD: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = NOP_WORD;
            cnt_d       = cnt_q + CNT_W'(1);
            if (ptr_q != LAST_ADDR) begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Session stays active through the edge that ends the final write cycle
      in_ready_d    = (state_d == LOAD) || (state_d == DRAIN);
      load_active_d = is_busy(state_d) || is_busy(state_q);
      load_done_d   = (state_q == DONE) && (state_d == DONE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         in_ready_q    <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         load_active_q <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         in_ready_q    <= in_ready_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         load_active_q <= load_active_d;
         load_done_q   <= load_done_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign load_active = load_active_q;
   assign load_done   = load_done_q;
   assign instr_count = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench with a write scoreboard for instr_loader.
module tb_instr_loader;

   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned ADDR_W = 10;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              load_active;
   logic              load_done;
   logic [ADDR_W:0]   instr_count;
   logic              overflow;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [ADDR_W+31:0] sb[$];

   instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .load_active(load_active), .load_done(load_done),
      .instr_count(instr_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every buffer write must match the oldest expected write
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'(mem_addr), 32'hDEAD_BEEF);
         end else begin
            logic [ADDR_W+31:0] e;
            e = sb.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
            check("wr_data", mem_wdata, e[31:0]);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Present one word and hold it until accepted; returns at the negedge after the handshake
   task automatic send(input logic [31:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
      end else if (exp_cnt < DEPTH) begin
         sb.push_back({ADDR_W'(exp_cnt), d});
         exp_cnt++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = $urandom_range(0, 1);
      in_data  = $urandom;
   endtask

   task automatic expect_pad();
      if (exp_cnt % 2 == 1) begin
         sb.push_back({ADDR_W'(exp_cnt), NOP});
         exp_cnt++;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_load_active", 32'(load_active), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);

      // Even program, back-to-back, with an ignored start mid-load
      do_start();
      check("ev_in_ready", 32'(in_ready), 32'd1);
      check("ev_load_active", 32'(load_active), 32'd1);
      send(32'h1111_0000, 1'b0);
      start = 1'b1;
      send(32'h1111_0001, 1'b0);
      start = 1'b0;
      send(32'h1111_0002, 1'b0);
      send(32'h1111_0003, 1'b1);
      check("ev_done_early", 32'(load_done), 32'd0);
      check("ev_active_early", 32'(load_active), 32'd1);
      check("ev_ready_off", 32'(in_ready), 32'd0);
      check("ev_count", 32'(instr_count), 32'd4);
      @(negedge clk);
      check("ev_done", 32'(load_done), 32'd1);
      check("ev_active_off", 32'(load_active), 32'd0);
      check("ev_overflow", 32'(overflow), 32'd0);

      // Odd program with gaps in in_valid, expect a NOP pad
      do_start();
      check("od_done_cleared", 32'(load_done), 32'd0);
      repeat (2) @(negedge clk);
      send(32'hA5A5_0001, 1'b0);
      @(negedge clk);
      send(32'hA5A5_0002, 1'b0);
      repeat (3) @(negedge clk);
      send(32'hA5A5_0003, 1'b1);
      expect_pad();
      check("od_done_k", 32'(load_done), 32'd0);
      check("od_count_k", 32'(instr_count), 32'd3);
      @(negedge clk);
      check("od_done_k1", 32'(load_done), 32'd0);
      check("od_active_k1", 32'(load_active), 32'd1);
      check("od_count_pad", 32'(instr_count), 32'd4);
      @(negedge clk);
      check("od_done", 32'(load_done), 32'd1);
      check("od_active_off", 32'(load_active), 32'd0);

      // Exactly DEPTH words
      do_start();
      for (int i = 0; i < DEPTH; i++) send($urandom, (i == DEPTH - 1));
      expect_pad();
      check("full_count", 32'(instr_count), 32'(DEPTH));
      check("full_done_early", 32'(load_done), 32'd0);
      @(negedge clk);
      check("full_done", 32'(load_done), 32'd1);
      check("full_overflow", 32'(overflow), 32'd0);

      // Overflow: DEPTH+6 words, tail discarded
      do_start();
      for (int i = 0; i < DEPTH + 6; i++) begin
         send($urandom, (i == DEPTH + 5));
         if (i == DEPTH + 1) begin
            check("ovf_drain_flag", 32'(overflow), 32'd1);
            check("ovf_drain_ready", 32'(in_ready), 32'd1);
         end
      end
      @(negedge clk);
      check("ovf_done", 32'(load_done), 32'd1);
      check("ovf_overflow", 32'(overflow), 32'd1);
      check("ovf_count", 32'(instr_count), 32'(DEPTH));

      // Start in DONE clears status; then reset mid-load
      do_start();
      check("re_done_cleared", 32'(load_done), 32'd0);
      check("re_ovf_cleared", 32'(overflow), 32'd0);
      check("re_count_cleared", 32'(instr_count), 32'd0);
      check("re_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 5; i++) send(32'hC0DE_0000 + 32'(i), 1'b0);
      rst = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      check("mr_in_ready", 32'(in_ready), 32'd0);
      check("mr_mem_we", 32'(mem_we), 32'd0);
      check("mr_mem_addr", 32'(mem_addr), 32'd0);
      check("mr_mem_wdata", mem_wdata, 32'd0);
      check("mr_load_active", 32'(load_active), 32'd0);
      check("mr_load_done", 32'(load_done), 32'd0);
      check("mr_count", 32'(instr_count), 32'd0);
      check("mr_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      check("mr_idle_ready", 32'(in_ready), 32'd0);

      // Fresh load after reset restarts at address 0
      do_start();
      send(32'hBEEF_0000, 1'b0);
      send(32'hBEEF_0001, 1'b1);
      expect_pad();
      @(negedge clk);
      check("rl_done", 32'(load_done), 32'd1);
      check("rl_count", 32'(instr_count), 32'd2);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
